// File: rtl/spike_detector_if.sv
// Sample-in / event-out bundle between an energy operator and the spike detector.
// The detector takes the slave side; the upstream operator / event consumer takes the master side.
interface spike_detector_if #(
    parameter int unsigned IN_BITS = 29,
    parameter int unsigned TS_BITS = 32
);
    logic               in_valid;
    logic [IN_BITS-1:0] data_in;
    logic               spike_valid;
    logic [IN_BITS-1:0] spike_peak;
    logic [TS_BITS-1:0] spike_ts;
    logic [IN_BITS-1:0] threshold;
    logic               busy;

    modport master (
        output in_valid, data_in,
        input  spike_valid, spike_peak, spike_ts, threshold, busy
    );

    modport slave (
        input  in_valid, data_in,
        output spike_valid, spike_peak, spike_ts, threshold, busy
    );
endinterface

// File: rtl/spike_detector.sv
// Adaptive-threshold spike detector: EMA background tracking, one event per excursion
// carrying peak value and timestamp, followed by a refractory hold-off.
module spike_detector #(
    parameter int unsigned IN_BITS   = 29,
    parameter int unsigned ALPHA_SH  = 8,
    parameter int unsigned THR_SH    = 3,
    parameter int unsigned THR_MIN   = 64,
    parameter int unsigned WARMUP    = 256,
    parameter int unsigned REFRACT   = 30,
    parameter int unsigned MAX_WIDTH = 64,
    parameter int unsigned TS_BITS   = 32
) (
    input  logic             clk,
    input  logic             rst,
    spike_detector_if.slave  bus
);
    localparam int unsigned ACC_BITS = IN_BITS + ALPHA_SH;
    localparam int unsigned SC_BITS  = IN_BITS + THR_SH;
    localparam int unsigned REFR_W   = $clog2(REFRACT + 2);
    localparam int unsigned WID_W    = $clog2(MAX_WIDTH + 2);

    typedef enum logic [1:0] {S_WARM, S_IDLE, S_ABOVE, S_REFRACT} state_t;

    state_t              state_q;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic                first_q;
    logic [TS_BITS-1:0]  sample_cnt_q;
    logic [REFR_W-1:0]   refr_cnt_q;
    logic [WID_W-1:0]    width_cnt_q, width_d;
    logic [IN_BITS-1:0]  peak_q, peak_d;
    logic [TS_BITS-1:0]  peak_ts_q, peak_ts_d;
    logic [IN_BITS-1:0]  thr_q, thr_d;
    logic [IN_BITS-1:0]  mean_d;
    logic [SC_BITS-1:0]  scaled;
    logic                above;
    logic                spike_valid_q;
    logic [IN_BITS-1:0]  spike_peak_q;
    logic [TS_BITS-1:0]  spike_ts_q;
    logic                busy_q;

    always_comb begin
        above = bus.data_in > thr_q;

        if (first_q)
            acc_d = ACC_BITS'(bus.data_in) << ALPHA_SH;
        else
            acc_d = acc_q + ACC_BITS'(bus.data_in) - (acc_q >> ALPHA_SH);

        mean_d = IN_BITS'(acc_d >> ALPHA_SH);
        scaled = SC_BITS'(mean_d) << THR_SH;

        // Saturate the scaled mean, then apply the floor.
        if (scaled > SC_BITS'({IN_BITS{1'b1}}))
            thr_d = '1;
        else
            thr_d = scaled[IN_BITS-1:0];
        if (thr_d < IN_BITS'(THR_MIN))
            thr_d = IN_BITS'(THR_MIN);

        peak_d    = peak_q;
        peak_ts_d = peak_ts_q;
        if (bus.data_in > peak_q) begin
            peak_d    = bus.data_in;
            peak_ts_d = sample_cnt_q;
        end

        width_d = width_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_WARM;
            acc_q         <= '0;
            first_q       <= 1'b1;
            sample_cnt_q  <= '0;
            refr_cnt_q    <= '0;
            width_cnt_q   <= '0;
            peak_q        <= '0;
            peak_ts_q     <= '0;
            thr_q         <= IN_BITS'(THR_MIN);
            spike_valid_q <= 1'b0;
            spike_peak_q  <= '0;
            spike_ts_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            spike_valid_q <= 1'b0;
            if (bus.in_valid) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
                unique case (state_q)
                    S_WARM: begin
                        acc_q   <= acc_d;
                        first_q <= 1'b0;
                        thr_q   <= thr_d;
                        if (sample_cnt_q == TS_BITS'(WARMUP - 1))
                            state_q <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (above) begin
                            peak_q      <= bus.data_in;
                            peak_ts_q   <= sample_cnt_q;
                            width_cnt_q <= WID_W'(1);
                            state_q     <= S_ABOVE;
                            busy_q      <= 1'b1;
                        end else begin
                            acc_q <= acc_d;
                            thr_q <= thr_d;
                        end
                    end
                    S_ABOVE: begin
                        peak_q    <= peak_d;
                        peak_ts_q <= peak_ts_d;
                        if (above)
                            width_cnt_q <= width_d;
                        // Emit on the terminating sample, using the peak including this sample.
                        if (!above || width_d == WID_W'(MAX_WIDTH)) begin
                            spike_valid_q <= 1'b1;
                            spike_peak_q  <= peak_d;
                            spike_ts_q    <= peak_ts_d;
                            refr_cnt_q    <= REFR_W'(REFRACT);
                            if (REFRACT == 0) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_REFRACT;
                            end
                        end
                    end
                    S_REFRACT: begin
                        refr_cnt_q <= refr_cnt_q - 1'b1;
                        if (refr_cnt_q == REFR_W'(1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= S_WARM;
                endcase
            end
        end
    end

    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_peak  = spike_peak_q;
    assign bus.spike_ts    = spike_ts_q;
    assign bus.threshold   = thr_q;
    assign bus.busy        = busy_q;
endmodule
